// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage MIPS pipe sequencer (init flush, RAW bubbles, branch flush, memory freeze).
// Optional PIPE_PERF_CNT_EN adds cyc_cnt/stall_cnt/flush_cnt performance counters.
module pipeline_ctrl #(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rs_used_id,
  input  logic        rt_used_id,
  input  logic [4:0]  addr_rs_id,
  input  logic [4:0]  addr_rt_id,
  input  logic        is_branch_exe,
  input  logic        is_branch_mem,
  input  logic [4:0]  regw_addr_exe,
  input  logic        wb_wen_exe,
  input  logic [4:0]  regw_addr_mem,
  input  logic        wb_wen_mem,
  input  logic [4:0]  regw_addr_wb,
  input  logic        wb_wen_wb,
  input  logic        inst_ack,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        if_rst,
  output logic        id_rst,
  output logic        exe_rst,
  output logic        mem_rst,
  output logic        wb_rst,
  output logic        if_en,
  output logic        id_en,
  output logic        exe_en,
  output logic        mem_en,
  output logic        wb_en,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] cyc_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic        mem_err
);
  typedef enum logic [1:0] {S_INIT, S_RUN, S_MWAIT} state_t;
  state_t state_q, state_d;
  logic [3:0] icnt_q, icnt_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic err_q, err_d;
  logic run, fz, bm, be, lo, hz, iw, raw;
  function automatic logic dep(input logic [4:0] a);
    return a != 5'd0 && ((wb_wen_exe && regw_addr_exe == a) ||
                         (wb_wen_mem && regw_addr_mem == a) ||
                         (wb_wen_wb  && regw_addr_wb  == a));
  endfunction
  always_comb begin
    run = state_q != S_INIT;
    fz  = run && mem_req && !mem_ack;
    raw = (rs_used_id && dep(addr_rs_id)) || (rt_used_id && dep(addr_rt_id));
    bm  = run && !fz && is_branch_mem;
    be  = run && !fz && !is_branch_mem && is_branch_exe;
    lo  = run && !fz && !is_branch_mem && !is_branch_exe;
    hz  = lo && raw;
    iw  = lo && !inst_ack;
  end
  // A held ID (hazard) must not also be cleared by the instruction-wait bubble.
  always_comb begin
    if_en   = run && !fz && !be && !hz && !iw;
    id_en   = run && !fz && !hz;
    exe_en  = run && !fz;
    mem_en  = run && !fz;
    wb_en   = run;
    if_rst  = !run;
    id_rst  = !run || bm || be || (iw && !hz);
    exe_rst = !run || bm || be || hz;
    mem_rst = !run;
    wb_rst  = !run || fz;
    mem_err = err_q;
  end
  always_comb begin
    state_d = (state_q == S_INIT) ? ((icnt_q == 4'(INIT_CYCLES - 1)) ? S_RUN : S_INIT)
                                  : (fz ? S_MWAIT : S_RUN);
    icnt_d  = (state_q == S_INIT) ? icnt_q + 4'd1 : 4'd0;
    wcnt_d  = fz ? ((wcnt_q == 8'hff) ? wcnt_q : wcnt_q + 8'd1) : 8'd0;
    err_d   = err_q || (fz && ({1'b0, wcnt_q} + 9'd1 >= 9'(MEM_TIMEOUT)));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      icnt_q  <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cyc_q, stall_q, flush_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      cyc_q   <= cyc_q + {31'd0, run};
      stall_q <= stall_q + {31'd0, fz || hz};
      flush_q <= flush_q + {31'd0, bm};
    end
  end
  assign cyc_cnt   = cyc_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed table vectors plus multi-cycle sequences for pipeline_ctrl.
module tb_pipeline_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic rs_used_id, rt_used_id, is_branch_exe, is_branch_mem;
  logic wb_wen_exe, wb_wen_mem, wb_wen_wb, inst_ack, mem_req, mem_ack;
  logic [4:0] addr_rs_id, addr_rt_id, regw_addr_exe, regw_addr_mem, regw_addr_wb;
  logic if_rst, id_rst, exe_rst, mem_rst, wb_rst, if_en, id_en, exe_en, mem_en, wb_en, mem_err;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cyc_cnt, stall_cnt, flush_cnt;
`endif
  int n_run = 0, n_fail = 0;

  pipeline_ctrl #(.INIT_CYCLES(4), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
    .addr_rs_id(addr_rs_id), .addr_rt_id(addr_rt_id),
    .is_branch_exe(is_branch_exe), .is_branch_mem(is_branch_mem),
    .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe),
    .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem),
    .regw_addr_wb(regw_addr_wb), .wb_wen_wb(wb_wen_wb),
    .inst_ack(inst_ack), .mem_req(mem_req), .mem_ack(mem_ack),
    .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
    .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
`ifdef PIPE_PERF_CNT_EN
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rsu, rtu;
    logic [4:0] rs, rt;
    logic be, bm;
    logic [4:0] ae; logic we;
    logic [4:0] am; logic wm;
    logic [4:0] aw; logic ww;
    logic ia, mr, ma;
    logic [4:0] en, clr;
  } vec_t;

  vec_t idle = '{0,0,5'd0,5'd0,0,0,5'd0,0,5'd0,0,5'd0,0,1,0,0,5'b11111,5'b00000};
  vec_t tab [$];

  task automatic apply(input vec_t v);
    rs_used_id = v.rsu; rt_used_id = v.rtu; addr_rs_id = v.rs; addr_rt_id = v.rt;
    is_branch_exe = v.be; is_branch_mem = v.bm;
    regw_addr_exe = v.ae; wb_wen_exe = v.we; regw_addr_mem = v.am; wb_wen_mem = v.wm;
    regw_addr_wb = v.aw; wb_wen_wb = v.ww; inst_ack = v.ia; mem_req = v.mr; mem_ack = v.ma;
  endtask

  // Compares {en[if..wb], rst[if..wb], mem_err}.
  task automatic chk(input string name, input logic [4:0] en, input logic [4:0] clr, input logic err);
    logic [10:0] got, exp;
    got = {if_en, id_en, exe_en, mem_en, wb_en, if_rst, id_rst, exe_rst, mem_rst, wb_rst, mem_err};
    exp = {en, clr, err};
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got en=%b rst=%b err=%b, expected en=%b rst=%b err=%b",
               name, got[10:6], got[5:1], got[0], exp[10:6], exp[5:1], exp[0]);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) next_cyc();
    rst = 1'b0;
    repeat (4) next_cyc();
  endtask

  initial begin
    vec_t v;
    //      rsu rtu rs    rt    be bm ae    we am    wm aw    ww ia mr ma en        clr
    tab.push_back('{0,0,5'd0,5'd0,0,0,5'd0,0,5'd0,0,5'd0,0,1,0,0,5'b11111,5'b00000});
    tab.push_back('{1,0,5'd5,5'd0,0,0,5'd5,1,5'd0,0,5'd0,0,1,0,0,5'b00111,5'b00100});
    tab.push_back('{1,0,5'd0,5'd0,0,0,5'd0,1,5'd0,0,5'd0,0,1,0,0,5'b11111,5'b00000});
    tab.push_back('{0,1,5'd0,5'd7,0,0,5'd0,0,5'd7,1,5'd0,0,1,0,0,5'b00111,5'b00100});
    tab.push_back('{1,0,5'd3,5'd0,0,0,5'd0,0,5'd0,0,5'd3,1,1,0,0,5'b00111,5'b00100});
    tab.push_back('{1,0,5'd5,5'd0,0,0,5'd5,0,5'd0,0,5'd0,0,1,0,0,5'b11111,5'b00000});
    tab.push_back('{0,0,5'd0,5'd9,0,0,5'd9,1,5'd0,0,5'd0,0,1,0,0,5'b11111,5'b00000});
    tab.push_back('{1,1,5'd4,5'd6,0,0,5'd1,1,5'd2,1,5'd3,1,1,0,0,5'b11111,5'b00000});
    tab.push_back('{0,0,5'd0,5'd0,0,0,5'd0,0,5'd0,0,5'd0,0,0,0,0,5'b01111,5'b01000});
    tab.push_back('{1,0,5'd5,5'd0,0,0,5'd5,1,5'd0,0,5'd0,0,0,0,0,5'b00111,5'b00100});
    tab.push_back('{0,0,5'd0,5'd0,1,0,5'd0,0,5'd0,0,5'd0,0,1,0,0,5'b01111,5'b01100});
    tab.push_back('{0,0,5'd0,5'd0,0,1,5'd0,0,5'd0,0,5'd0,0,1,0,0,5'b11111,5'b01100});
    tab.push_back('{0,0,5'd0,5'd0,1,1,5'd0,0,5'd0,0,5'd0,0,0,0,0,5'b11111,5'b01100});
    tab.push_back('{1,0,5'd5,5'd0,1,0,5'd5,1,5'd0,0,5'd0,0,1,0,0,5'b01111,5'b01100});
    tab.push_back('{0,0,5'd0,5'd0,0,0,5'd0,0,5'd0,0,5'd0,0,1,1,1,5'b11111,5'b00000});
    tab.push_back('{0,0,5'd0,5'd0,0,1,5'd0,0,5'd0,0,5'd0,0,1,1,0,5'b00001,5'b00001});
    tab.push_back('{1,0,5'd5,5'd0,0,0,5'd5,1,5'd0,0,5'd0,0,0,1,0,5'b00001,5'b00001});
    tab.push_back('{0,0,5'd0,5'd0,0,0,5'd0,0,5'd0,0,5'd0,0,1,0,0,5'b11111,5'b00000});

    apply(idle);
    rst = 1'b1;
    #2 chk("reset_async", 5'b00000, 5'b11111, 1'b0);
    repeat (3) next_cyc();
    chk("reset_held", 5'b00000, 5'b11111, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) chk($sformatf("init_cyc%0d", i + 1), 5'b00000, 5'b11111, 1'b0);
    end
    @(negedge clk) chk("init_done", 5'b11111, 5'b00000, 1'b0);

    foreach (tab[i]) begin
      next_cyc();
      apply(tab[i]);
      @(negedge clk) chk($sformatf("vec%0d", i), tab[i].en, tab[i].clr, 1'b0);
    end

    next_cyc(); v = idle; v.be = 1'b1; apply(v);
    @(negedge clk) chk("br_cyc1", 5'b01111, 5'b01100, 1'b0);
    next_cyc(); v = idle; v.bm = 1'b1; apply(v);
    @(negedge clk) chk("br_cyc2", 5'b11111, 5'b01100, 1'b0);
    next_cyc(); apply(idle);
    @(negedge clk) chk("br_cyc3", 5'b11111, 5'b00000, 1'b0);

    v = idle; v.mr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cyc(); apply(v);
      @(negedge clk) chk($sformatf("mwait%0d", i + 1), 5'b00001, 5'b00001, 1'b0);
    end
    next_cyc(); v.ma = 1'b1; apply(v);
    @(negedge clk) chk("mwait_ack", 5'b11111, 5'b00000, 1'b0);

    next_cyc(); v = idle; v.mr = 1'b1; v.bm = 1'b1; apply(v);
    @(negedge clk) chk("fz_br_freeze", 5'b00001, 5'b00001, 1'b0);
    next_cyc(); v.ma = 1'b1; apply(v);
    @(negedge clk) chk("fz_br_ack", 5'b11111, 5'b01100, 1'b0);

    v = idle; v.mr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_cyc(); apply(v);
      @(negedge clk) chk($sformatf("tmo_wait%0d", i + 1), 5'b00001, 5'b00001, 1'b0);
    end
    next_cyc();
    @(negedge clk) chk("tmo_set", 5'b00001, 5'b00001, 1'b1);
    next_cyc(); v.ma = 1'b1; apply(v);
    @(negedge clk) chk("tmo_ack_sticky", 5'b11111, 5'b00000, 1'b1);
    next_cyc(); apply(idle);
    @(negedge clk) chk("tmo_idle_sticky", 5'b11111, 5'b00000, 1'b1);

    #2 rst = 1'b1;
    #1 chk("rst_midop", 5'b00000, 5'b11111, 1'b0);
    next_cyc(); rst = 1'b0;
    repeat (3) next_cyc();
    @(negedge clk) chk("reinit_hold", 5'b00000, 5'b11111, 1'b0);
    @(negedge clk) chk("reinit_done", 5'b11111, 5'b00000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Sequencing controller for the 5-stage MIPS pipelined datapath.
- Generates the per-stage reset/enable pairs (if/id/exe/mem/wb) from decoded register usage, the datapath's EXE/MEM/WB feedback and the memory handshakes.
- Inserts bubbles for RAW hazards, flushes wrong-path instructions after jumps/branches, and freezes the pipe on memory wait.
- Runs a power-on flush sequence before the pipe starts.

Parameters:
- INIT_CYCLES, 4, cycles all stage resets stay asserted after rst deasserts (1..15).
- MEM_TIMEOUT, 255, consecutive MEM wait cycles before mem_err sets (1..255).

Ports:
- clk  in  1  main clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs_used_id  in  1  ID instruction reads rs.
- rt_used_id  in  1  ID instruction reads rt.
- addr_rs_id  in  5  rs field of ID instruction.
- addr_rt_id  in  5  rt field of ID instruction.
- is_branch_exe  in  1  EXE holds a jump/branch.
- is_branch_mem  in  1  MEM holds a jump/branch; PC target valid.
- regw_addr_exe  in  5  EXE destination register.
- wb_wen_exe  in  1  EXE writes a register.
- regw_addr_mem  in  5  MEM destination register.
- wb_wen_mem  in  1  MEM writes a register.
- regw_addr_wb  in  5  WB destination register.
- wb_wen_wb  in  1  WB writes a register.
- inst_ack  in  1  instruction memory returned inst_data this cycle.
- mem_req  in  1  MEM stage mem_ren|mem_wen.
- mem_ack  in  1  data memory completed access this cycle.
- if_rst, id_rst, exe_rst, mem_rst, wb_rst  out  1 each  synchronous stage clears to datapath.
- if_en, id_en, exe_en, mem_en, wb_en  out  1 each  stage load enables.
- mem_err  out  1  sticky MEM timeout flag.

Behaviour:
- FSM states:
  - S_INIT: entered asynchronously on rst. All *_rst=1, all *_en=0. A 4-bit counter loads 0 and increments while rst is low. When count==INIT_CYCLES-1, go to S_RUN.
  - S_RUN: normal operation.
  - S_MWAIT: entered from S_RUN when mem_req && !mem_ack. Returns to S_RUN in the cycle mem_ack=1. The wait counter clears on entry.
- Stage controls are combinational from state and inputs, so they take effect at the next edge.
- Default in S_RUN: all *_en=1, all *_rst=0.
- Priority, highest first:
  1. Memory wait: mem_req && !mem_ack, in S_RUN or S_MWAIT.
     - if/id/exe/mem_en=0 (freeze).
     - wb_rst=1 (bubble into WB, so there is no double writeback).
  2. Branch in MEM:
     - if_en=1 (PC loads target).
     - id_rst=1, exe_rst=1.
  3. Branch in EXE:
     - if_en=0 (hold PC).
     - id_rst=1, exe_rst=1 (discard the two wrong-path fetches).
     - Total taken/untaken penalty is fixed at 3 cycles; no prediction.
  4. RAW hazard:
     - Condition: (rs_used_id && addr_rs_id!=0 && addr_rs_id matches any stage X in {exe,mem,wb} with wb_wen_X && regw_addr_X==addr_rs_id), or the same test for rt.
     - Response: if_en=0, id_en=0, exe_rst=1 (bubble into EXE). There is no forwarding.
     - Register $0 never causes a hazard.
  5. Instruction wait: !inst_ack → if_en=0, id_rst=1 (bubble into ID).
- Rules 4 and 5 may coexist: the hazard holds ID, so id_rst is suppressed whenever id_en=0.
- Rule 1 masks everything below it. Branch and hazard conditions are re-evaluated when the freeze ends.
- Timeout:
  - The wait counter increments each S_MWAIT cycle.
  - On reaching MEM_TIMEOUT, mem_err sets and stays set until rst. The freeze continues.
- Reset values:
  - All *_rst=1, all *_en=0, mem_err=0, state=S_INIT, counters=0.
  - rst asserted mid-operation: outputs go to reset values immediately, regardless of current state; the sequence restarts at S_INIT.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, adds three 32-bit output ports, all cleared by rst and wrapping modulo 2^32:
  - cyc_cnt: increments every S_RUN/S_MWAIT cycle.
  - stall_cnt: increments on each cycle where rule 1 or rule 4 is active.
  - flush_cnt: increments once per branch, on the cycle is_branch_mem=1 and no freeze is active.
- Without the macro: no such ports, logic or registers exist.

Test Plan:
- Init sequence: rst=1 for 3 cycles, then 0 → all *_rst=1 for exactly 4 cycles, then *_en=1, *_rst=0 on cycle 5.
- RAW hazard, EXE producer: rs_used_id=1, addr_rs_id=5, wb_wen_exe=1, regw_addr_exe=5 → if_en=0, id_en=0, exe_rst=1 that cycle.
- Same hazard with addr_rs_id=0 → no stall.
- Branch flush: is_branch_exe=1 for one cycle, then is_branch_mem=1 for one cycle → cycle1: if_en=0, id_rst=exe_rst=1; cycle2: if_en=1, id_rst=exe_rst=1; cycle3: defaults.
- Memory wait: mem_req=1, mem_ack=0 for 3 cycles, then 1 → if/id/exe/mem_en=0 and wb_rst=1 for 3 cycles, normal on the ack cycle.
- Simultaneous: mem wait together with is_branch_mem=1 → freeze wins, if_en=0. After ack, if_en=1 and id_rst=1.
- Timeout: MEM_TIMEOUT=8, mem_ack held 0 → mem_err rises after 8 wait cycles and stays 1 after ack, until rst.
